alimentador_instrucoes: RTL and testbench
=========================================

Name: alimentador_instrucoes

Overview:
Upstream instruction-feed stage for processador_multiciclo. Holds a small program memory and drives the processor's DIN and Run inputs. Issues one instruction at a time, supplies the mvi immediate word in the following cycle, then waits for the processor's Done before fetching the next word. Replaces hand-driven DIN/Run stimulus, so whole programs run on the multicycle core.

Parameters:
AW, 4, program-memory address width; DEPTH = 2**AW words
START_ADDR, 0, PC load value on Start
HALT_WORD, 16'hFFFF, memory word that ends the program (never issued)
TIMEOUT, 16, maximum cycles spent waiting for Done before aborting

Ports:
Clock  in  1  system clock; all state updates on posedge
Resetn  in  1  synchronous reset, active-high (Resetn=1 resets on the next posedge)
Start  in  1  begin execution at START_ADDR; sampled only in IDLE/HALT
Done  in  1  from processor: current instruction complete
Prog_we  in  1  program-memory write enable; honoured only in IDLE/HALT
Prog_addr  in  AW  program-memory write address
Prog_data  in  16  program-memory write data
DIN  out  16  instruction/immediate word to processor DIN
Run  out  1  to processor Run; one-cycle pulse per issued instruction
PC  out  AW  address of the next word to read
Busy  out  1  high in FETCH/EXEC/WAIT
Halted  out  1  program ended (halt word, end of memory, or timeout)
Error  out  1  set only by timeout
Instr_count  out  16  count of instructions completed (Done accepted)

Behaviour:
- Reset (Resetn=1 at posedge): state=IDLE, DIN=0, Run=0, PC=START_ADDR, Busy=0, Halted=0, Error=0, Instr_count=0, timeout counter=0. Reset overrides every state, including mid-instruction. Memory contents are not cleared.
- Memory: DEPTH x 16 register array with combinational read at PC. A write occurs at posedge when Prog_we=1 and state is IDLE/HALT. Otherwise the write is ignored.
- IDLE: Run=0. Start=1 -> PC<=START_ADDR, go to FETCH.
- FETCH (1 cycle):
  - If mem[PC]==HALT_WORD -> HALT, Run=0, DIN unchanged.
  - Else DIN<=mem[PC], Run<=1, PC<=PC+1, go to EXEC.
- EXEC (1 cycle; processor T0 registers IR at mid-cycle):
  - Run<=0.
  - If DIN[8:6]==3'b001 (mvi): DIN<=mem[PC], PC<=PC+1, so the immediate is valid during processor T1.
  - Else DIN is held.
  - Go to WAIT. Done=1 here is accepted as in WAIT.
- WAIT: timeout counter increments each cycle.
  - Done=1 -> Instr_count<=Instr_count+1, counter<=0.
    - If PC wrapped to 0 (last word consumed) -> HALT.
    - Else -> FETCH.
  - Counter reaching TIMEOUT with Done=0 -> HALT, Error<=1, Run=0.
- HALT: Halted=1, Busy=0, Run=0, DIN holds last value. Start=1 -> Halted<=0, Error<=0, Instr_count<=0, PC<=START_ADDR, go to FETCH.
- Start while Busy is ignored. Start and Prog_we in the same cycle in IDLE: the write happens and the start proceeds. A write takes effect before that address is fetched.
- Run is never asserted for two consecutive cycles, and never while Busy=0.
- PC arithmetic is modulo DEPTH. A mvi immediate fetched at DEPTH-1 wraps to address 0 and the program then halts after Done.
- Latency, start to first Run=1: 1 cycle (FETCH on the posedge after Start).

Test Plan:
- mem={16'h0050,16'h0001,HALT_WORD} (mvi R2,1), Start -> DIN=0x0050 with Run=1 for exactly 1 cycle, next cycle DIN=0x0001, Run=0; after Done: Instr_count=1, PC=2, Halted=1, processor R2=1.
- mem={16'h0060,16'h000A,16'h0005,HALT_WORD} (mvi R4,10; mv R0,R5) -> two Run pulses, DIN sequence 0x0060, 0x000A, 0x0005; Instr_count=2; second pulse only after first Done.
- mem={16'h00E2,HALT_WORD} (sub R4,R2) with R4=10, R2=6 -> single Run pulse, DIN held at 0x00E2 through WAIT, R4=4 on Done, Instr_count=1.
- TIMEOUT=8, Done tied 0, mem[0]=16'h0005 -> exactly 8 WAIT cycles then Halted=1, Error=1, Run=0, Instr_count=0. A following Start clears Error.
- AW=2, four non-halt non-mvi words, Done returned each instruction -> 4 Run pulses, PC wraps to 0, Halted=1, Instr_count=4.
- Resetn=1 asserted during WAIT of 2nd instruction -> next cycle all outputs at reset values, state IDLE. Prog_we during Busy does not alter memory; verify by readback on a new run.

Source files
------------

// File: rtl/alimentador_instrucoes_if.sv
// Feeder-to-processor bus: instruction/immediate word, Run/Done handshake,
// and the program-memory write port used while the feeder is idle or halted.
interface alimentador_instrucoes_if #(
  parameter int AW = 4
);
  logic [15:0]   DIN;
  logic          Run;
  logic          Done;
  logic          Prog_we;
  logic [AW-1:0] Prog_addr;
  logic [15:0]   Prog_data;

  modport master (
    output DIN, Run,
    input  Done, Prog_we, Prog_addr, Prog_data
  );

  modport slave (
    input  DIN, Run,
    output Done, Prog_we, Prog_addr, Prog_data
  );
endinterface

// File: rtl/alimentador_instrucoes.sv
// Instruction feeder for processador_multiciclo: walks a small program memory,
// pulses Run per instruction, supplies mvi immediates and waits for Done.
module alimentador_instrucoes #(
  parameter int             AW         = 4,
  parameter logic [AW-1:0]  START_ADDR = '0,
  parameter logic [15:0]    HALT_WORD  = 16'hFFFF,
  parameter int             TIMEOUT    = 16
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   Start,
  alimentador_instrucoes_if.master bus,
  output logic [AW-1:0]          PC,
  output logic                   Busy,
  output logic                   Halted,
  output logic                   Error,
  output logic [15:0]            Instr_count
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT, HALT} state_t;

  state_t        state_q, state_nx;
  logic [15:0]   din_q, din_nx;
  logic          run_q, run_nx;
  logic [AW-1:0] pc_q, pc_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [15:0]   instr_q, instr_nx;
  logic          error_q, error_nx;

  logic [15:0]   mem [DEPTH];
  logic [15:0]   rd_word;
  logic          prog_open;

  assign rd_word   = mem[pc_q];
  assign prog_open = (state_q == IDLE) || (state_q == HALT);

  // NOTE: the program memory has no reset; clearing it would turn the array
  // into flops with a reset tree and would wipe a loaded program on reset.
  always_ff @(posedge Clock) begin
    if (bus.Prog_we && prog_open)
      mem[bus.Prog_addr] <= bus.Prog_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q <= IDLE;
      din_q   <= '0;
      run_q   <= 1'b0;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
      instr_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      din_q   <= din_nx;
      run_q   <= run_nx;
      pc_q    <= pc_nx;
      cnt_q   <= cnt_nx;
      instr_q <= instr_nx;
      error_q <= error_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nx = state_q;
    din_nx   = din_q;
    run_nx   = 1'b0;
    pc_nx    = pc_q;
    cnt_nx   = cnt_q;
    instr_nx = instr_q;
    error_nx = error_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          pc_nx    = START_ADDR;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (rd_word == HALT_WORD) begin
          state_nx = HALT;
        end else begin
          din_nx   = rd_word;
          run_nx   = 1'b1;
          pc_nx    = pc_q + AW'(1);
          cnt_nx   = '0;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        state_nx = WAIT;
        // mvi: the immediate follows so it is on DIN during processor T1
        if (din_q[8:6] == 3'b001) begin
          din_nx = rd_word;
          pc_nx  = pc_q + AW'(1);
        end
        if (bus.Done) begin
          instr_nx = instr_q + 16'd1;
          cnt_nx   = '0;
          state_nx = (pc_nx == '0) ? HALT : FETCH;
        end
      end
      WAIT: begin
        if (bus.Done) begin
          instr_nx = instr_q + 16'd1;
          cnt_nx   = '0;
          // a PC of zero here means the last memory word was consumed
          state_nx = (pc_q == '0) ? HALT : FETCH;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          error_nx = 1'b1;
          state_nx = HALT;
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
      HALT: begin
        if (Start) begin
          error_nx = 1'b0;
          instr_nx = '0;
          pc_nx    = START_ADDR;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.DIN     = din_q;
  assign bus.Run     = run_q;
  assign PC          = pc_q;
  assign Busy        = (state_q == FETCH) || (state_q == EXEC) || (state_q == WAIT);
  assign Halted      = (state_q == HALT);
  assign Error       = error_q;
  assign Instr_count = instr_q;

endmodule

// File: tb/tb_alimentador_instrucoes.sv
// Directed bench for alimentador_instrucoes: one DUT with TIMEOUT=8 for the
// program scenarios, and one with AW=2 for the end-of-memory wrap.
module tb_alimentador_instrucoes;

  logic Clock = 1'b0;
  logic Resetn;
  logic start_a, start_b;
  logic [3:0]  pc_a;
  logic [1:0]  pc_b;
  logic busy_a, halted_a, error_a, busy_b, halted_b, error_b;
  logic [15:0] cnt_a, cnt_b;

  int n_vec = 0;
  int n_err = 0;
  logic prev_run_a = 1'b0;

  alimentador_instrucoes_if #(.AW(4)) ia ();
  alimentador_instrucoes_if #(.AW(2)) ib ();

  alimentador_instrucoes #(.AW(4), .TIMEOUT(8)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .Start(start_a), .bus(ia),
    .PC(pc_a), .Busy(busy_a), .Halted(halted_a), .Error(error_a),
    .Instr_count(cnt_a)
  );

  alimentador_instrucoes #(.AW(2), .TIMEOUT(16)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .Start(start_b), .bus(ib),
    .PC(pc_b), .Busy(busy_b), .Halted(halted_b), .Error(error_b),
    .Instr_count(cnt_b)
  );

  always #5 Clock = ~Clock;

  // Run must be a single-cycle pulse and only while Busy
  always @(negedge Clock) begin
    if (ia.Run) begin
      n_vec++;
      if (prev_run_a || !busy_a) begin
        n_err++;
        $display("FAIL run_pulse prev_run=%b busy=%b required prev_run=0 busy=1", prev_run_a, busy_a);
      end
    end
    prev_run_a = ia.Run;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write_a(input logic [3:0] addr, input logic [15:0] data);
    ia.Prog_we = 1'b1; ia.Prog_addr = addr; ia.Prog_data = data;
    tick();
    ia.Prog_we = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] addr, input logic [15:0] data);
    ib.Prog_we = 1'b1; ib.Prog_addr = addr; ib.Prog_data = data;
    tick();
    ib.Prog_we = 1'b0;
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic done_pulse_a();
    ia.Done = 1'b1;
    tick();
    ia.Done = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b1;
    tick(); tick();
    Resetn = 1'b0;
    n_vec++;
    if ({ia.DIN, ia.Run, pc_a, busy_a, halted_a, error_a, cnt_a} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_a din=%h run=%b pc=%h busy=%b halted=%b err=%b cnt=%0d required all zero",
               ia.DIN, ia.Run, pc_a, busy_a, halted_a, error_a, cnt_a);
    end
    n_vec++;
    if ({ib.DIN, ib.Run, pc_b, busy_b, halted_b, error_b, cnt_b} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_b din=%h run=%b pc=%h busy=%b halted=%b err=%b cnt=%0d required all zero",
               ib.DIN, ib.Run, pc_b, busy_b, halted_b, error_b, cnt_b);
    end
  endtask

  task automatic test_mvi();
    write_a(4'd0, 16'h0050); write_a(4'd1, 16'h0001); write_a(4'd2, 16'hFFFF);
    start_pulse_a();
    n_vec++;
    if ({ia.Run, busy_a} !== 2'b01) begin
      n_err++; $display("FAIL mvi_fetch run/busy got %b required 01", {ia.Run, busy_a});
    end
    tick();
    n_vec++;
    if ({ia.Run, ia.DIN, pc_a} !== {1'b1, 16'h0050, 4'd1}) begin
      n_err++; $display("FAIL mvi_issue run/din/pc got %h required %h", {ia.Run, ia.DIN, pc_a}, {1'b1, 16'h0050, 4'd1});
    end
    tick();
    n_vec++;
    if ({ia.Run, ia.DIN, pc_a} !== {1'b0, 16'h0001, 4'd2}) begin
      n_err++; $display("FAIL mvi_imm run/din/pc got %h required %h", {ia.Run, ia.DIN, pc_a}, {1'b0, 16'h0001, 4'd2});
    end
    done_pulse_a();
    tick();
    n_vec++;
    if ({halted_a, busy_a, pc_a, cnt_a, ia.DIN} !== {1'b1, 1'b0, 4'd2, 16'd1, 16'h0001}) begin
      n_err++; $display("FAIL mvi_end halted=%b busy=%b pc=%0d cnt=%0d din=%h required 1 0 2 1 0001",
                        halted_a, busy_a, pc_a, cnt_a, ia.DIN);
    end
  endtask

  task automatic test_two_instr();
    write_a(4'd0, 16'h0060); write_a(4'd1, 16'h000A); write_a(4'd2, 16'h0005); write_a(4'd3, 16'hFFFF);
    start_pulse_a();
    n_vec++;
    if ({halted_a, cnt_a} !== 17'h0) begin
      n_err++; $display("FAIL two_restart halted=%b cnt=%0d required 0 0", halted_a, cnt_a);
    end
    tick();
    n_vec++;
    if ({ia.Run, ia.DIN} !== {1'b1, 16'h0060}) begin
      n_err++; $display("FAIL two_issue1 run/din got %h required %h", {ia.Run, ia.DIN}, {1'b1, 16'h0060});
    end
    tick();
    n_vec++;
    if ({ia.Run, ia.DIN} !== {1'b0, 16'h000A}) begin
      n_err++; $display("FAIL two_imm run/din got %h required %h", {ia.Run, ia.DIN}, {1'b0, 16'h000A});
    end
    tick(); tick();
    n_vec++;
    if ({ia.Run, busy_a} !== 2'b01) begin
      n_err++; $display("FAIL two_hold run/busy got %b required 01", {ia.Run, busy_a});
    end
    done_pulse_a();
    tick();
    n_vec++;
    if ({ia.Run, ia.DIN, pc_a, cnt_a} !== {1'b1, 16'h0005, 4'd3, 16'd1}) begin
      n_err++; $display("FAIL two_issue2 run/din/pc/cnt got %h required %h", {ia.Run, ia.DIN, pc_a, cnt_a}, {1'b1, 16'h0005, 4'd3, 16'd1});
    end
    tick();
    done_pulse_a();
    tick();
    n_vec++;
    if ({halted_a, pc_a, cnt_a} !== {1'b1, 4'd3, 16'd2}) begin
      n_err++; $display("FAIL two_end halted=%b pc=%0d cnt=%0d required 1 3 2", halted_a, pc_a, cnt_a);
    end
  endtask

  task automatic test_sub();
    write_a(4'd0, 16'h00E2); write_a(4'd1, 16'hFFFF);
    start_pulse_a();
    tick();
    n_vec++;
    if ({ia.Run, ia.DIN} !== {1'b1, 16'h00E2}) begin
      n_err++; $display("FAIL sub_issue run/din got %h required %h", {ia.Run, ia.DIN}, {1'b1, 16'h00E2});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({ia.Run, ia.DIN, pc_a} !== {1'b0, 16'h00E2, 4'd1}) begin
        n_err++; $display("FAIL sub_hold%0d run/din/pc got %h required %h", i, {ia.Run, ia.DIN, pc_a}, {1'b0, 16'h00E2, 4'd1});
      end
    end
    done_pulse_a();
    tick();
    n_vec++;
    if ({halted_a, pc_a, cnt_a} !== {1'b1, 4'd1, 16'd1}) begin
      n_err++; $display("FAIL sub_end halted=%b pc=%0d cnt=%0d required 1 1 1", halted_a, pc_a, cnt_a);
    end
  endtask

  task automatic test_timeout();
    write_a(4'd0, 16'h0005);
    start_pulse_a();
    tick(); tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      n_vec++;
      if ({busy_a, halted_a, error_a} !== 3'b100) begin
        n_err++; $display("FAIL timeout_wait%0d busy/halted/err got %b required 100", i, {busy_a, halted_a, error_a});
      end
    end
    tick();
    n_vec++;
    if ({halted_a, error_a, ia.Run, cnt_a} !== {3'b110, 16'd0}) begin
      n_err++; $display("FAIL timeout_abort halted=%b err=%b run=%b cnt=%0d required 1 1 0 0", halted_a, error_a, ia.Run, cnt_a);
    end
    start_pulse_a();
    n_vec++;
    if ({halted_a, error_a, busy_a} !== 3'b001) begin
      n_err++; $display("FAIL timeout_clear halted/err/busy got %b required 001", {halted_a, error_a, busy_a});
    end
  endtask

  task automatic test_reset_mid();
    Resetn = 1'b1;
    tick();
    Resetn = 1'b0;
    write_a(4'd0, 16'h0005); write_a(4'd1, 16'h0006); write_a(4'd2, 16'hFFFF);
    start_pulse_a();
    tick(); tick();
    done_pulse_a();
    tick(); tick();
    Resetn = 1'b1;
    tick();
    Resetn = 1'b0;
    n_vec++;
    if ({ia.DIN, ia.Run, pc_a, busy_a, halted_a, error_a, cnt_a} !== 40'h0) begin
      n_err++; $display("FAIL reset_mid din=%h run=%b pc=%h busy=%b halted=%b err=%b cnt=%0d required all zero",
                        ia.DIN, ia.Run, pc_a, busy_a, halted_a, error_a, cnt_a);
    end
  endtask

  task automatic test_busy_write();
    start_pulse_a();
    tick(); tick();
    ia.Prog_we = 1'b1; ia.Prog_addr = 4'd2; ia.Prog_data = 16'h0005;
    done_pulse_a();
    ia.Prog_we = 1'b0;
    tick(); tick();
    done_pulse_a();
    tick();
    n_vec++;
    if ({halted_a, pc_a, cnt_a} !== {1'b1, 4'd2, 16'd2}) begin
      n_err++; $display("FAIL busy_write halted=%b pc=%0d cnt=%0d required 1 2 2", halted_a, pc_a, cnt_a);
    end
  endtask

  task automatic test_start_with_write();
    ia.Prog_we = 1'b1; ia.Prog_addr = 4'd0; ia.Prog_data = 16'hFFFF;
    start_pulse_a();
    ia.Prog_we = 1'b0;
    tick();
    n_vec++;
    if ({halted_a, pc_a, cnt_a, error_a, ia.DIN} !== {1'b1, 4'd0, 16'd0, 1'b0, 16'h0006}) begin
      n_err++; $display("FAIL start_write halted=%b pc=%0d cnt=%0d err=%b din=%h required 1 0 0 0 0006",
                        halted_a, pc_a, cnt_a, error_a, ia.DIN);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) write_b(2'(k), 16'h0005 + 16'(k));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if ({ib.Run, ib.DIN, pc_b} !== {1'b1, 16'h0005 + 16'(k), 2'(k + 1)}) begin
        n_err++; $display("FAIL wrap_issue%0d run/din/pc got %h required %h", k, {ib.Run, ib.DIN, pc_b}, {1'b1, 16'h0005 + 16'(k), 2'(k + 1)});
      end
      tick();
      ib.Done = 1'b1;
      tick();
      ib.Done = 1'b0;
    end
    n_vec++;
    if ({halted_b, pc_b, cnt_b, error_b} !== {1'b1, 2'd0, 16'd4, 1'b0}) begin
      n_err++; $display("FAIL wrap_end halted=%b pc=%0d cnt=%0d err=%b required 1 0 4 0", halted_b, pc_b, cnt_b, error_b);
    end
  endtask

  initial begin
    Resetn = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ia.Done = 1'b0; ia.Prog_we = 1'b0; ia.Prog_addr = '0; ia.Prog_data = '0;
    ib.Done = 1'b0; ib.Prog_we = 1'b0; ib.Prog_addr = '0; ib.Prog_data = '0;
    test_reset();
    test_mvi();
    test_two_instr();
    test_sub();
    test_timeout();
    test_reset_mid();
    test_busy_write();
    test_start_with_write();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
